alu_share_arbiter: RTL

//  Shares one instance of the existing combinational `alu` between NREQ requesters (e.g. EX stage, branch unit, debug port).

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu.sv | 32 +++
 rtl/alu_rr_arbiter.sv | 42 ++++
 rtl/alu_share_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU sharing arbiter.
//   WIDTH          : datapath width of the shared alu (32)
//   alu_op_e       : alucontrol encodings understood by the alu
//   alu_op_legal() : 1 when a 3-bit control code is one of alu_op_e
//   arb_state_e    : arbiter FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

    function automatic logic alu_op_legal(input logic [2:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Existing 32-bit combinational ALU.
//   a, b       in  32  operands
//   alucontrol in  3   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed)
//   result     out 32  result, 0 for unsupported codes
//   zero       out 1   result == 0
// -----------------------------------------------------------------------------
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alucontrol,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        result = '0;
        case (alucontrol)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = a + b;
            3'b110:  result = a - b;
            3'b111:  result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Combinational arbiter: picks one requester and returns it one-hot and as an
// index. Round-robin by default, searching from ptr and wrapping; with
// ALU_ARB_FIXED_PRIO_EN defined the lowest index always wins and ptr is unused.
//   req   in  NREQ  pending requests
//   ptr   in  IDXW  round-robin start position
//   grant out NREQ  one-hot winner (0 when no request)
//   idx   out IDXW  index of winner (0 when no request)
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);

    // Walk priority positions from lowest to highest priority; the last hit
    // overwrites earlier ones, so the highest-priority requester wins.
    always_comb begin
        logic [IDXW-1:0] slot;
        grant = '0;
        idx   = '0;
        slot  = '0;
        for (int p = NREQ - 1; p >= 0; p--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            slot = IDXW'(p);
`else
            slot = IDXW'((int'(ptr) + p) % NREQ);
`endif
            if (req[slot]) begin
                grant       = '0;
                grant[slot] = 1'b1;
                idx         = slot;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational alu between NREQ requesters. One op at a time:
// IDLE grants and latches operands, EXEC runs the alu from registers, RESP
// holds the registered result until the owner takes it.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index)
// instead of round-robin.
//   clk        in   1             clock
//   rst_n      in   1             synchronous active-low reset
//   req_valid  in   NREQ          op pending per requester
//   req_ready  out  NREQ          one-hot accept, only in IDLE
//   req_a      in   NREQ x WIDTH  left operands
//   req_b      in   NREQ x WIDTH  right operands
//   req_ctrl   in   NREQ x 3      alucontrol codes
//   rsp_valid  out  NREQ          one-hot result-held flag
//   rsp_ready  in   NREQ          result consumed (owner bit only)
//   rsp_data   out  WIDTH         result, 0 outside RESP
//   rsp_zero   out  1             zero flag, 0 outside RESP
//   rsp_err    out  1             illegal ctrl code, 0 outside RESP
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
    input  logic [NREQ-1:0][2:0]        req_ctrl,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic                        rsp_zero,
    output logic                        rsp_err
);

    import alu_pkg::*;

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e       state;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  owner_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             err_q;
    logic [NREQ-1:0]  rsp_valid_q;

    logic [NREQ-1:0]  grant;
    logic [IDXW-1:0]  grant_idx;
    logic [IDXW-1:0]  ptr_next;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    alu_rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    alu u_alu (
        .a          (a_q),
        .b          (b_q),
        .alucontrol (ctrl_q),
        .result     (alu_out),
        .zero       (alu_zero)
    );

    // Accept is combinational from the arbiter; suppressed while reset is held
    // so nothing appears to be accepted on a cycle that reset will discard.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;

    assign ptr_next = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);

    // Response regs are cleared on leaving RESP, so outputs read 0 elsewhere.
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: operand/result regs are reset as well, since reset must leave every output at 0.
            state       <= IDLE;
            rr_ptr      <= '0;
            owner_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        a_q     <= req_a[grant_idx];
                        b_q     <= req_b[grant_idx];
                        ctrl_q  <= req_ctrl[grant_idx];
                        owner_q <= grant_idx;
                        rr_ptr  <= ptr_next;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_op_legal(ctrl_q)) begin
                        res_q  <= alu_out;
                        zero_q <= alu_zero;
                        err_q  <= 1'b0;
                    end else begin
                        res_q  <= '0;
                        zero_q <= 1'b1;
                        err_q  <= 1'b1;
                    end
                    rsp_valid_q <= NREQ'(1) << owner_q;
                    state       <= RESP;
                end
                RESP: begin
                    // Only the owner's rsp_ready completes the response.
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        res_q       <= '0;
                        zero_q      <= 1'b0;
                        err_q       <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
